// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the multi-cycle integer divider.
//   - DIV_CONTROL / DIVU_CONTROL : ALU control codes the decoder maps to start/signed_div
//   - div_state_t                : divider FSM state encoding (2-bit)
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH    = 32;

    localparam logic [4:0]  DIV_CONTROL  = 5'b11010;
    localparam logic [4:0]  DIVU_CONTROL = 5'b11011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one radix-2 restoring division step (combinational).
//   i_rem, i_quo  : partial remainder / quotient-dividend shift register
//   i_divisor     : divisor magnitude
//   o_rem, o_quo  : values after one shift + trial subtract
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits and
    // the top bit of the difference is a clean borrow flag.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    always_comb begin
        o_rem = w_shift[WIDTH-1:0];
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
        end
        o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU unit, one quotient bit per cycle.
//   clk, resetn        : clock, async active-low reset
//   start, signed_div  : request (sampled in IDLE only), 1=signed
//   a, b               : dividend / divisor, sampled with start
//   annul              : abort; returns to IDLE with no result
//   busy, done         : iterating / one-cycle result-valid pulse
//   hi_out, lo_out     : remainder / quotient, held between results
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_t       r_state;
    div_state_t       w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_a_neg = signed_div & a[WIDTH-1];
    assign w_b_neg = signed_div & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    // Correction is applied to the final step's output so the result lands on E32.
    assign w_q_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (annul) begin
            w_next = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: if (start) w_next = (b == '0) ? DIV_DONE : DIV_RUN;
                DIV_RUN:  if (w_last) w_next = DIV_DONE;
                default:  w_next = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == DIV_RUN);
        done = (r_state == DIV_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (!annul) begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        if (b == '0) begin
                            r_lo <= '1;
                            r_hi <= a;
                        end else begin
                            r_rem <= '0;
                            r_quo <= w_a_mag;
                            r_div <= w_b_mag;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// A behavioural model (plain 64-bit arithmetic plus a countdown) predicts
// busy/done/hi_out/lo_out every cycle; directed cases pin literal results.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference division straight from the arithmetic rules.
    task automatic ref_div(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (tb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ta;
        end else if (ts) begin
            sa = longint'($signed(ta));
            sb = longint'($signed(tb));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = ta / tb;
            r = ta % tb;
        end
    endtask

    // Model: cycles left in the iteration, pending result, visible outputs.
    int          m_left;
    logic        m_done;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    always @(posedge clk or negedge resetn) begin
        logic [31:0] q, r;
        if (!resetn) begin
            m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (annul) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
                end
            end
        end else if (start && !annul) begin
            ref_div(a, b, signed_div, q, r);
            if (b == 32'd0) begin
                m_hi = r; m_lo = q; m_done = 1'b1;
            end else begin
                m_phi = r; m_plo = q; m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("hi_out", hi_out, m_hi);
        chk("lo_out", lo_out, m_lo);
    end

    // Issue one operation; start held for 'hold' edges, operands scrambled after E0.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                          input int hold, output int lat);
        a = ta; b = tb; signed_div = ts; start = 1'b1;
        lat = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat >= hold) start = 1'b0;
            a = $urandom; b = $urandom; signed_div = 1'($urandom);
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] q, r, ra, rb;
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;

        ref_div(32'd100, 32'd7, 1'b0, q, r);
        chk("model_divu_q", q, 32'd14);
        chk("model_divu_r", r, 32'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
        chk("model_div_q", q, 32'hFFFF_FFFD);
        chk("model_div_r", r, 32'hFFFF_FFFF);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
        chk("model_ovf_q", q, 32'h8000_0000);
        chk("model_ovf_r", r, 32'd0);

        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 1'b0, 1, lat);
        chk("t1_latency", 32'(lat), 32'd33);
        chk("t1_lo", lo_out, 32'd14);
        chk("t1_hi", hi_out, 32'd2);

        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1, lat);
        chk("t2_div_lo", lo_out, 32'hFFFF_FFFD);
        chk("t2_div_hi", hi_out, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 2, lat);
        chk("t2_divu_lo", lo_out, 32'h7FFF_FFFC);
        chk("t2_divu_hi", hi_out, 32'd1);

        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, lat);
        chk("t3_latency", 32'(lat), 32'd33);
        chk("t3_lo", lo_out, 32'h8000_0000);
        chk("t3_hi", hi_out, 32'd0);

        run_op(32'h1234, 32'd0, 1'b0, 2, lat);
        chk("t4_latency", 32'(lat), 32'd1);
        chk("t4_lo", lo_out, 32'hFFFF_FFFF);
        chk("t4_hi", hi_out, 32'h1234);

        // Annul mid-run: prior result must survive, no done.
        run_op(32'd100, 32'd7, 1'b0, 1, lat);
        a = 32'd55; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1 annul = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_lo", lo_out, 32'd14);
        chk("t5_hi", hi_out, 32'd2);
        run_op(32'd55, 32'd3, 1'b0, 1, lat);
        chk("t5_lo2", lo_out, 32'd18);
        chk("t5_hi2", hi_out, 32'd1);

        // Annul together with start in IDLE: nothing latched.
        a = 32'd9; b = 32'd0; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1 start = 1'b0; annul = 1'b0;
        chk("t5_annul_start_done", 32'(done), 32'd0);
        chk("t5_annul_start_lo", lo_out, 32'd18);
        @(posedge clk); #1;

        // Asynchronous reset between edges mid-run.
        a = 32'd1000; b = 32'd3; signed_div = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_hi", hi_out, 32'd0);
        chk("t6_lo", lo_out, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 1, lat);
        chk("t6_lo2", lo_out, 32'hFFFF_FFF2);
        chk("t6_hi2", hi_out, 32'd2);

        // Random sweep with corner operand shapes.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 6))
                0: rb = 32'd1;
                1: rb = ra;
                2: ra = 32'd0;
                3: rb = 32'd0;
                4: rb = 32'($urandom_range(1, 20)) * ((($urandom & 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom), $urandom_range(1, 2), lat);
            chk("rand_latency", 32'(lat), (rb == 32'd0) ? 32'd1 : 32'd33);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
